// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a small byte FIFO read through a ready/pop handshake.
// Define UART_RX_MAJORITY_EN to take each bit sample as a 2-of-3 vote over the last three synchronized values.
module uart_rx_fifo #(
   parameter int CLK_FREQ            = 66_000_000,
   parameter int BAUD_RATE           = 9600,
   parameter int FIFO_DEPTH_BITWIDTH = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   input  logic       rd_en,
   input  logic       clr_err,
   output logic [7:0] data,
   output logic       data_ready,
   output logic       busy,
   output logic       framing_error,
   output logic       overrun
);

   localparam int BIT_TIME = CLK_FREQ / BAUD_RATE;
   localparam int HALF     = BIT_TIME / 2;
   localparam int CNT_W    = (BIT_TIME > 2) ? $clog2(BIT_TIME) : 1;
   localparam int AW       = FIFO_DEPTH_BITWIDTH;
   localparam int DEPTH    = 1 << AW;
`ifdef UART_RX_MAJORITY_EN
   localparam int MIN_BT   = 4;
`else
   localparam int MIN_BT   = 2;
`endif

   generate
      if (BIT_TIME < MIN_BT || AW < 1) begin : g_bad_cfg
         $error("uart_rx_fifo: BIT_TIME %0d / FIFO_DEPTH_BITWIDTH %0d out of range", BIT_TIME, AW);
      end
   endgenerate

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

   state_t           state, state_nxt;
   logic             rx_meta, rxs, smp;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bit_cnt;
   logic [7:0]       shreg;
   logic             tick, half_pt, shift_en, push, ferr_set;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         rx_meta <= rx;
         rxs     <= rx_meta;
      end
   end

`ifdef UART_RX_MAJORITY_EN
   // hist[0] is rxs one cycle back, hist[1] two cycles back
   logic [1:0] hist;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) hist <= 2'b11;
      else     hist <= {hist[0], rxs};
   end
   assign smp = (rxs & hist[0]) | (rxs & hist[1]) | (hist[0] & hist[1]);
`else
   assign smp = rxs;
`endif

   // cnt holds j in cycle S0+j during START, then restarts at 0 right after the start sample
   assign tick    = (cnt == CNT_W'(BIT_TIME - 1));
   assign half_pt = (cnt == CNT_W'(HALF));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (!rxs) state_nxt = S_START;
         S_START: if (half_pt) state_nxt = smp ? S_IDLE : S_DATA;
         S_DATA:  if (tick && bit_cnt == 3'd7) state_nxt = S_STOP;
         S_STOP:  if (tick) state_nxt = smp ? S_IDLE : S_BREAK;
         S_BREAK: if (rxs) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy     = (state != S_IDLE);
      shift_en = (state == S_DATA) && tick;
      push     = (state == S_STOP) && tick && smp;
      ferr_set = (state == S_STOP) && tick && !smp;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt     <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               cnt     <= rxs ? '0 : CNT_W'(1);
               bit_cnt <= '0;
            end
            S_START: cnt <= half_pt ? '0 : cnt + 1'b1;
            S_DATA, S_STOP: begin
               cnt <= tick ? '0 : cnt + 1'b1;
               if (shift_en) begin
                  shreg   <= {smp, shreg[7:1]};
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            default: cnt <= '0;
         endcase
      end
   end

   logic [AW:0] wr_ptr, rd_ptr;
   logic [7:0]  mem [DEPTH];
   logic        empty, full, pop, wr, ovr_set;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop     = rd_en && !empty;
   // a pop frees the slot in the same cycle, so a full FIFO still accepts the push
   assign wr      = push && (!full || pop);
   assign ovr_set = push && full && !pop;

   always_ff @(posedge clk) begin
      if (wr) mem[wr_ptr[AW-1:0]] <= shreg;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         framing_error <= 1'b0;
         overrun       <= 1'b0;
      end else begin
         if (wr)  wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         framing_error <= ferr_set | (framing_error & ~clr_err);
         overrun       <= ovr_set  | (overrun & ~clr_err);
      end
   end

   assign data_ready = !empty;
   assign data       = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo at BIT_TIME = 4, depth 4: stimulus pushes expected bytes,
// a monitor pops the DUT and compares.
module tb_uart_rx_fifo;
   localparam int BT = 4;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst, rx, rd_en, clr_err;
   logic [7:0] data;
   logic       data_ready, busy, framing_error, overrun;
   logic       mon_pop = 1'b0, tb_pop = 1'b0;
   bit         mon_en = 1'b0, mon_rand = 1'b0;
   bit         exp_ferr = 1'b0, exp_ovr = 1'b0;
   logic [7:0] exp_q[$];
   int         checks = 0, errors = 0;

   assign rd_en = mon_pop | tb_pop;

   always #5 clk = ~clk;

   uart_rx_fifo #(.CLK_FREQ(4), .BAUD_RATE(1), .FIFO_DEPTH_BITWIDTH(2)) dut (
      .clk(clk), .rst(rst), .rx(rx), .rd_en(rd_en), .clr_err(clr_err),
      .data(data), .data_ready(data_ready), .busy(busy),
      .framing_error(framing_error), .overrun(overrun));

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // drives the first ncyc cycles of a frame; spike flips rx for one cycle at that offset
   task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int spike, input int ncyc);
      logic [9:0] bits;
      bits = {stop_ok, b, 1'b0};
      for (int c = 0; c < ncyc; c++) begin
         rx = bits[c / BT] ^ (c == spike);
         cyc(1);
      end
   endtask

   task automatic model_push(input logic [7:0] b);
      if (exp_q.size() < DEPTH) exp_q.push_back(b);
      else exp_ovr = 1'b1;
   endtask

   task automatic good_frame(input logic [7:0] b);
      send_frame(b, 1'b1, -1, 10 * BT);
      model_push(b);
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 2000) begin @(negedge clk); n++; end
      if (exp_q.size() != 0) begin
         checks++; errors++;
         $display("FAIL drain_timeout got %0d bytes left expected 0", exp_q.size());
      end
      cyc(2);
   endtask

   task automatic pulse_clr();
      @(posedge clk); #1 clr_err = 1'b1;
      cyc(1);
      clr_err = 1'b0;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         mon_pop = 1'b0;
         if (mon_en && data_ready && (!mon_rand || $urandom_range(1, 0) == 1)) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL mon_unexpected got %0h expected no byte", data);
            end else begin
               chk("mon_data", data, exp_q.pop_front());
            end
            mon_pop = 1'b1;
         end else if (mon_en && !data_ready) begin
            chk("mon_empty_data", data, 0);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; rx = 1'b1; clr_err = 1'b0;
      cyc(3);
      @(negedge clk);
      chk("rst_data", data, 0);
      chk("rst_ready", data_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ferr", framing_error, 0);
      chk("rst_ovr", overrun, 0);
      @(posedge clk); #1 rst = 1'b0;
      cyc(3);

      // frame timing: stop sample at S0+38, ready at S0+39
      send_frame(8'hA5, 1'b1, -1, 10 * BT);
      model_push(8'hA5);
      @(negedge clk);
      chk("a5_ready_early", data_ready, 0);
      chk("a5_busy_stop", busy, 1);
      @(negedge clk);
      chk("a5_ready", data_ready, 1);
      chk("a5_data", data, 8'hA5);
      chk("a5_busy_end", busy, 0);
      mon_rand = 1'b0; mon_en = 1'b1;
      drain();
      mon_en = 1'b0;
      @(negedge clk);
      chk("a5_ready_after_pop", data_ready, 0);
      chk("a5_data_after_pop", data, 0);

      // one-cycle low pulse: false start
      cyc(1);
      rx = 1'b0; cyc(1); rx = 1'b1;
      cyc(2);
      @(negedge clk);
      chk("glitch_busy", busy, 1);
      cyc(2);
      @(negedge clk);
      chk("glitch_busy_end", busy, 0);
      chk("glitch_ready", data_ready, 0);
      chk("glitch_ferr", framing_error, 0);

      // framing error, line held low for 8 bit times
      cyc(1);
      send_frame(8'h3C, 1'b0, -1, 10 * BT);
      exp_ferr = 1'b1;
      cyc(7 * BT);
      @(negedge clk);
      chk("ferr_set", framing_error, exp_ferr);
      chk("ferr_break_busy", busy, 1);
      chk("ferr_ready", data_ready, 0);
      cyc(1); rx = 1'b1; cyc(4);
      @(negedge clk);
      chk("ferr_break_exit", busy, 0);
      pulse_clr(); exp_ferr = 1'b0;
      @(negedge clk);
      chk("ferr_clr", framing_error, exp_ferr);

      // five back-to-back frames into a depth-4 FIFO
      cyc(1);
      for (int i = 1; i <= 5; i++) good_frame(8'(i));
      @(negedge clk);
      chk("ovr_pre", overrun, 0);
      @(negedge clk);
      chk("ovr_set", overrun, exp_ovr);
      chk("ovr_head", data, 8'h01);
      mon_en = 1'b1;
      drain();
      mon_en = 1'b0;
      @(negedge clk);
      chk("ovr_ready_after", data_ready, 0);
      pulse_clr(); exp_ovr = 1'b0;
      @(negedge clk);
      chk("ovr_clr", overrun, exp_ovr);

      // full FIFO, pop in the stop-sample cycle of 0x77
      cyc(1);
      for (int i = 0; i < 4; i++) good_frame(8'h21 + 8'(i));
      send_frame(8'h77, 1'b1, -1, 10 * BT);
      tb_pop = 1'b1;
      @(negedge clk);
      chk("full_head", data, exp_q.pop_front());
      model_push(8'h77);
      @(posedge clk); #1 tb_pop = 1'b0;
      @(negedge clk);
      chk("full_pop_ovr", overrun, exp_ovr);
      chk("full_pop_head", data, 8'h22);
      mon_en = 1'b1;
      drain();
      mon_en = 1'b0;

      // reset during DATA bit 4 with a byte waiting
      cyc(1);
      good_frame(8'h11);
      send_frame(8'hC3, 1'b1, -1, 22);
      @(negedge clk);
      chk("mid_busy", busy, 1);
      chk("mid_ready", data_ready, 1);
      rst = 1'b1; rx = 1'b1;
      #1;
      chk("mid_rst_data", data, 0);
      chk("mid_rst_ready", data_ready, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_ferr", framing_error, 0);
      chk("mid_rst_ovr", overrun, 0);
      exp_q.delete();
      cyc(2); rst = 1'b0; cyc(3);
      good_frame(8'h5A);
      mon_en = 1'b1;
      drain();
      mon_en = 1'b0;

      // one-cycle high spike at the centre of data bit 0 of 0x00
      cyc(2);
      send_frame(8'h00, 1'b1, BT + BT / 2, 10 * BT);
`ifdef UART_RX_MAJORITY_EN
      model_push(8'h00);
`else
      model_push(8'h01);
`endif
      mon_en = 1'b1;
      drain();

      // random frames, false starts and framing errors with random pops
      mon_rand = 1'b1;
      for (int it = 0; it < 40; it++) begin
         int k;
         k = $urandom_range(9, 0);
         if (k == 0) begin
            rx = 1'b0; cyc(1); rx = 1'b1; cyc(5);
         end else if (k == 1) begin
            send_frame(8'($urandom), 1'b0, -1, 10 * BT);
            rx = 1'b1; exp_ferr = 1'b1;
            cyc(4);
         end else begin
            good_frame(8'($urandom));
            cyc($urandom_range(3, 0));
         end
      end
      drain();
      mon_en = 1'b0;
      @(negedge clk);
      chk("rand_ferr", framing_error, exp_ferr);
      chk("rand_ovr", overrun, exp_ovr);
      chk("rand_ready", data_ready, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
